// File: rtl/line_seq_pkg.sv
// rtl/line_seq_pkg.sv - shared types and widths for the line sequencer
package line_seq_pkg;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COL_W   = 3;
    localparam int VAL_W   = 9;
    localparam int LINES_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETX,
        SETY,
        SETCOL,
        GO,
        WAIT_DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic [COL_W-1:0] col;
        logic             go;
    } cmd_t;

endpackage

// File: rtl/line_cmd_fifo.sv
// rtl/line_cmd_fifo.sv - command queue ahead of the line sequencer FSM
module line_cmd_fifo
    import line_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_sequencer.sv
// rtl/line_sequencer.sv - queues line commands and strobes them into the user interface
module line_sequencer
    import line_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [X_W-1:0]     i_cmd_x,
    input  logic [Y_W-1:0]     i_cmd_y,
    input  logic [COL_W-1:0]   i_cmd_col,
    input  logic               i_cmd_go,
    output logic [VAL_W-1:0]   o_val,
    output logic               o_setx,
    output logic               o_sety,
    output logic               o_setcol,
    output logic               o_go,
    input  logic               i_done,
    output logic               o_busy,
    output logic [LINES_W-1:0] o_lines
);

    state_t             state;
    cmd_t               cmd_q;
    cmd_t               fifo_in;
    cmd_t               fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               done_q;
    logic [LINES_W-1:0] lines_q;

    assign fifo_in     = {i_cmd_x, i_cmd_y, i_cmd_col, i_cmd_go};
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign o_cmd_ready = !fifo_full;
    assign o_busy      = (state != IDLE) || !fifo_empty;
    assign o_lines     = lines_q;

    line_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .push      (i_cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs are loaded on the transition into a state so they are valid for that state's cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            cmd_q    <= '0;
            done_q   <= 1'b0;
            lines_q  <= '0;
            o_val    <= '0;
            o_setx   <= 1'b0;
            o_sety   <= 1'b0;
            o_setcol <= 1'b0;
            o_go     <= 1'b0;
        end else begin
            done_q   <= i_done;
            o_val    <= '0;
            o_setx   <= 1'b0;
            o_sety   <= 1'b0;
            o_setcol <= 1'b0;
            o_go     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q  <= fifo_head;
                        o_setx <= 1'b1;
                        o_val  <= fifo_head.x;
                        state  <= SETX;
                    end
                end
                SETX: begin
                    o_sety <= 1'b1;
                    o_val  <= {1'b0, cmd_q.y};
                    state  <= SETY;
                end
                SETY: begin
                    o_setcol <= 1'b1;
                    o_val    <= {6'b0, cmd_q.col};
                    state    <= SETCOL;
                end
                SETCOL: begin
                    if (cmd_q.go) begin
                        o_go  <= 1'b1;
                        state <= GO;
                    end else begin
                        state <= IDLE;
                    end
                end
                GO: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // done_q carries i_done from the GO cycle, so a level already high does not count
                    if (i_done && !done_q) begin
                        lines_q <= lines_q + 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_sequencer.sv
// tb/tb_line_sequencer.sv - directed self-checking bench for line_sequencer
module tb_line_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [8:0]  i_cmd_x;
    logic [7:0]  i_cmd_y;
    logic [2:0]  i_cmd_col;
    logic        i_cmd_go;
    logic [8:0]  o_val;
    logic        o_setx;
    logic        o_sety;
    logic        o_setcol;
    logic        o_go;
    logic        i_done;
    logic        o_busy;
    logic [15:0] o_lines;

    int n_checks = 0;
    int n_fail   = 0;

    line_sequencer #(.DEPTH(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_x     (i_cmd_x),
        .i_cmd_y     (i_cmd_y),
        .i_cmd_col   (i_cmd_col),
        .i_cmd_go    (i_cmd_go),
        .o_val       (o_val),
        .o_setx      (o_setx),
        .o_sety      (o_sety),
        .o_setcol    (o_setcol),
        .o_go        (o_go),
        .i_done      (i_done),
        .o_busy      (o_busy),
        .o_lines     (o_lines)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [3:0] strb();
        return {o_setx, o_sety, o_setcol, o_go};
    endfunction

    task automatic expect_out(input string tag, input logic [3:0] s, input logic [8:0] v);
        check_eq({tag, "_strb"}, 32'(strb()), 32'(s));
        check_eq({tag, "_val"}, 32'(o_val), 32'(v));
    endtask

    task automatic set_cmd(input logic [8:0] x, input logic [7:0] y, input logic [2:0] col, input logic go);
        i_cmd_x   = x;
        i_cmd_y   = y;
        i_cmd_col = col;
        i_cmd_go  = go;
    endtask

    // Waits (bounded) for SETX, then checks the rest of the strobe sequence; gap = cycles waited
    task automatic run_cmd(input logic [8:0] x, input logic [7:0] y, input logic [2:0] col,
                           input logic go, output int gap);
        gap = 0;
        while (!o_setx && gap < 20) begin
            tick();
            gap++;
        end
        expect_out("run_setx", 4'b1000, x);
        tick();
        expect_out("run_sety", 4'b0100, {1'b0, y});
        tick();
        expect_out("run_setcol", 4'b0010, {6'b0, col});
        if (go) begin
            tick();
            expect_out("run_go", 4'b0001, 9'd0);
            tick();
            i_done = 1'b1;
            tick();
            i_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gap;
        logic seen;
        i_clk       = 1'b0;
        i_reset     = 1'b0;
        i_cmd_valid = 1'b0;
        i_done      = 1'b0;
        set_cmd(9'd0, 8'd0, 3'd0, 1'b0);

        #3;
        check_eq("rst_ready", 32'(o_cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_lines", 32'(o_lines), 32'd0);
        expect_out("rst", 4'b0000, 9'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        tick();

        // single drawing command, latency and strobe order
        set_cmd(9'd234, 8'd123, 3'd7, 1'b1);
        i_cmd_valid = 1'b1;
        check_eq("a_ready", 32'(o_cmd_ready), 32'd1);
        tick();
        i_cmd_valid = 1'b0;
        expect_out("a_t1", 4'b0000, 9'd0);
        check_eq("a_busy_t1", 32'(o_busy), 32'd1);
        tick();
        expect_out("a_setx", 4'b1000, 9'd234);
        tick();
        expect_out("a_sety", 4'b0100, 9'd123);
        tick();
        expect_out("a_setcol", 4'b0010, 9'd7);
        tick();
        expect_out("a_go", 4'b0001, 9'd0);
        tick();
        expect_out("a_wait", 4'b0000, 9'd0);
        check_eq("a_busy_wait", 32'(o_busy), 32'd1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check_eq("a_lines", 32'(o_lines), 32'd1);
        check_eq("a_busy_end", 32'(o_busy), 32'd0);

        // load-only command never pulses o_go
        set_cmd(9'd10, 8'd20, 3'd2, 1'b0);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        expect_out("b_setx", 4'b1000, 9'd10);
        tick();
        expect_out("b_sety", 4'b0100, 9'd20);
        tick();
        expect_out("b_setcol", 4'b0010, 9'd2);
        tick();
        expect_out("b_idle", 4'b0000, 9'd0);
        check_eq("b_busy", 32'(o_busy), 32'd0);
        check_eq("b_lines", 32'(o_lines), 32'd1);

        // done already high before GO must fall and rise again
        i_done = 1'b1;
        set_cmd(9'd1, 8'd2, 3'd3, 1'b1);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        repeat (5) tick();
        expect_out("c_wait", 4'b0000, 9'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("c_held_busy", 32'(o_busy), 32'd1);
            check_eq("c_held_lines", 32'(o_lines), 32'd1);
        end
        i_done = 1'b0;
        tick();
        check_eq("c_low_busy", 32'(o_busy), 32'd1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check_eq("c_lines", 32'(o_lines), 32'd2);
        check_eq("c_busy", 32'(o_busy), 32'd0);

        // fill the queue while the FSM stalls in WAIT_DONE
        set_cmd(9'd5, 8'd6, 3'd1, 1'b1);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        repeat (5) tick();
        expect_out("d_wait", 4'b0000, 9'd0);
        for (int q = 0; q < 4; q++) begin
            set_cmd(9'(100 + q), 8'(50 + q), 3'(q), 1'b0);
            i_cmd_valid = 1'b1;
            tick();
        end
        set_cmd(9'd104, 8'd54, 3'd4, 1'b0);
        check_eq("d_full_ready", 32'(o_cmd_ready), 32'd0);
        tick();
        check_eq("d_held_ready", 32'(o_cmd_ready), 32'd0);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check_eq("d_p_lines", 32'(o_lines), 32'd3);
        check_eq("d_p_ready", 32'(o_cmd_ready), 32'd0);
        tick();
        expect_out("d_q1_setx", 4'b1000, 9'd100);
        check_eq("d_pop_ready", 32'(o_cmd_ready), 32'd1);
        tick();
        i_cmd_valid = 1'b0;
        expect_out("d_q1_sety", 4'b0100, 9'd50);
        tick();
        expect_out("d_q1_setcol", 4'b0010, 9'd0);
        for (int q = 1; q < 5; q++) begin
            run_cmd(9'(100 + q), 8'(50 + q), 3'(q), 1'b0, gap);
            check_eq("d_gap", 32'(gap), 32'd2);
        end
        tick();
        check_eq("d_busy_end", 32'(o_busy), 32'd0);
        check_eq("d_lines_end", 32'(o_lines), 32'd3);

        // reset asserted during SETY drops everything
        for (int q = 0; q < 3; q++) begin
            set_cmd(9'(200 + q), 8'(1 + q), 3'd1, 1'b1);
            i_cmd_valid = 1'b1;
            tick();
        end
        i_cmd_valid = 1'b0;
        expect_out("e_sety", 4'b0100, 9'd1);
        #2 i_reset = 1'b0;
        #1;
        expect_out("e_rst", 4'b0000, 9'd0);
        check_eq("e_rst_busy", 32'(o_busy), 32'd0);
        check_eq("e_rst_ready", 32'(o_cmd_ready), 32'd1);
        check_eq("e_rst_lines", 32'(o_lines), 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | (|strb()) | o_busy;
        end
        check_eq("e_quiet", 32'(seen), 32'd0);

        // line counter wrap, preloaded to avoid 65536 real draws
        set_cmd(9'd7, 8'd7, 3'd7, 1'b1);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        repeat (5) tick();
        force dut.lines_q = 16'hFFFF;
        #1;
        release dut.lines_q;
        check_eq("f_preload", 32'(o_lines), 32'h0000FFFF);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check_eq("f_wrap", 32'(o_lines), 32'd0);
        check_eq("f_busy", 32'(o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
